bram_toggle_sweep_ctrl: RTL and testbench
=========================================

// Module: bram_toggle_sweep_ctrl
// PURPOSE
//  Sequencer for the block-RAM daisy-chain power load. It sweeps TOGGLE_RATE (0..100 %) from a start to a stop value in fixed steps.
//  At each step it waits for the load to settle, then handshakes one sample with the power-measurement logic.
//  It owns the chain reset and TOGGLE_RATE inputs of every block_ram_daisy_chain instance.
// PARAMETERS
//  RST_CYCLES     16    cycles chain_rst is held high at sweep start
//  SETTLE_CYCLES  1024  cycles between a rate change and meas_req assertion
//  ACK_TIMEOUT    4096  max cycles meas_req waits for meas_ack
//  CNT_W          20    width of the shared dwell/timeout counter; must hold max(RST,SETTLE,ACK_TIMEOUT)
// PORTS
//  clk              in   1  single clock for the whole block
//  irst_n           in   1  asynchronous active-low reset
//  start            in   1  1-cycle pulse; starts a sweep (honoured in IDLE/DONE only)
//  abort            in   1  1-cycle pulse; kills a sweep in progress
//  cfg_start_rate   in   7  first toggle rate, 0..100
//  cfg_stop_rate    in   7  last toggle rate, 0..100
//  cfg_step         in   7  rate increment, >=1
//  meas_ack         in   1  measurement-side ack for meas_req
//  toggle_rate      out  7  to TOGGLE_RATE of all chains
//  chain_rst        out  1  to irst of all chains, active high
//  meas_req         out  1  level request: sample power at toggle_rate
//  step_idx         out  7  index of the current step, 0-based
//  busy             out  1  sweep in progress
//  done             out  1  sweep finished; level, cleared by next start
//  cfg_err          out  1  last start had invalid config; sticky until next start
//  timeout_err      out  1  at least one ack timed out; sticky until next start
// BEHAVIOUR
//  Reset (async, irst_n=0): state=IDLE, toggle_rate=0, chain_rst=1, meas_req=0, step_idx=0, busy=0, done=0, cfg_err=0, timeout_err=0, counter=0.
//  All outputs are registered. Config is latched on the accepted start and ignored afterwards.
//  States: IDLE, RST_CHAIN, SETTLE, MEASURE, STEP, DONE.
//  IDLE/DONE: chain_rst=1, toggle_rate=0, meas_req=0.
//    start in cycle t clears done, cfg_err and timeout_err.
//    Config is invalid if cfg_step==0, stop>100, or start>stop.
//      Invalid: at t+1, state=DONE, done=1, cfg_err=1, busy stays 0, no chain activity.
//      Valid: at t+1, state=RST_CHAIN, busy=1, toggle_rate=cfg_start_rate, step_idx=0.
//  RST_CHAIN: chain_rst=1 for exactly RST_CYCLES cycles, then SETTLE. chain_rst=0 from the first SETTLE cycle.
//  SETTLE: counts SETTLE_CYCLES cycles, then MEASURE. toggle_rate is stable throughout.
//  MEASURE: meas_req=1 from the first MEASURE cycle.
//    meas_ack sampled high: meas_req=0 next cycle, go to STEP.
//    No ack within ACK_TIMEOUT cycles: timeout_err=1, meas_req=0, go to STEP.
//    meas_ack while meas_req=0 is ignored.
//  STEP (1 cycle): next rate computed 8-bit wide (no 7-bit wrap): nxt = toggle_rate + step.
//    toggle_rate==stop: go to DONE; done=1, busy=0, toggle_rate=0, chain_rst=1.
//    Otherwise: toggle_rate = min(nxt, stop), step_idx+1, go to SETTLE. Chains are not reset between steps.
//  The stop rate is always measured even if it is not on the step grid, e.g. 0,30,60,90,100 for step 30.
//  start==stop: exactly one measurement.
//  abort in any non-IDLE state takes priority over every transition, including the same-cycle ack.
//    Next cycle: state=IDLE, meas_req=0, chain_rst=1, toggle_rate=0, busy=0, done stays 0.
//  start while busy is ignored. start and abort in the same cycle in IDLE/DONE: abort wins; start is dropped.
//  Reset mid-sweep: immediate return to the reset values. No partial-sweep state is retained.
// TESTING
//  T1: cfg 0/100/25, ack 3 cycles after each req
//      -> rates 0,25,50,75,100; 5 reqs; step_idx 0..4; done=1, busy=0; timeout_err=0.
//  T2: cfg 10/95/40
//      -> rates 10,50,90,95 (stop clipped); 4 reqs; no 7-bit overflow on 90+40.
//  T3: cfg_step=0, then separately start=60/stop=20
//      -> cfg_err=1 and done=1 at t+1; chain_rst stays 1; meas_req never asserted.
//  T4: cfg 0/0/1, meas_ack tied low
//      -> meas_req high for ACK_TIMEOUT cycles; timeout_err=1; done=1.
//  T5: abort during SETTLE of step 2, then abort coincident with meas_ack
//      -> IDLE next cycle both times; done=0; toggle_rate=0; chain_rst=1.
//  T6: irst_n low mid-MEASURE, then start pulse issued during busy
//      -> all outputs at reset values asynchronously; the start issued during busy has no effect.

Source files
------------

// File: rtl/bram_toggle_sweep_ctrl_if.sv
// Command, status and measurement-handshake bundle of the BRAM toggle-rate sweep sequencer.
// The sweep controller takes the slave side; the host or measurement logic takes the master side.
interface bram_toggle_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [6:0] cfg_start_rate;
  logic [6:0] cfg_stop_rate;
  logic [6:0] cfg_step;
  logic       meas_ack;
  logic [6:0] toggle_rate;
  logic       chain_rst;
  logic       meas_req;
  logic [6:0] step_idx;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic       timeout_err;

  modport master (
    output start, abort, cfg_start_rate, cfg_stop_rate, cfg_step, meas_ack,
    input  toggle_rate, chain_rst, meas_req, step_idx, busy, done, cfg_err, timeout_err
  );

  modport slave (
    input  start, abort, cfg_start_rate, cfg_stop_rate, cfg_step, meas_ack,
    output toggle_rate, chain_rst, meas_req, step_idx, busy, done, cfg_err, timeout_err
  );
endinterface

// File: rtl/bram_toggle_sweep_ctrl.sv
// Sweeps the daisy-chain TOGGLE_RATE from a start to a stop value, settling at each step
// and handshaking one power sample per step with the measurement logic.
module bram_toggle_sweep_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned ACK_TIMEOUT   = 4096,
  parameter int unsigned CNT_W         = 20
) (
  input logic                 clk,
  input logic                 irst_n,
  bram_toggle_sweep_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST_CHAIN = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_STEP      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [6:0]       RATE_MAX    = 7'd100;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 32'd1);

  function automatic logic cfg_valid(input logic [6:0] s, input logic [6:0] p, input logic [6:0] st);
    return (st != 7'd0) && (p <= RATE_MAX) && (s <= p);
  endfunction

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       rate_r;
  logic [6:0]       stop_r;
  logic [6:0]       step_r;
  logic [6:0]       idx_r;
  logic             chain_rst_r;
  logic             meas_req_r;
  logic             busy_r;
  logic             done_r;
  logic             cfg_err_r;
  logic             timeout_err_r;

  logic [7:0]       sum_s;
  logic [6:0]       next_rate_s;

  // Next rate is formed 8 bits wide so 90+40 cannot wrap before clipping to the stop rate.
  assign sum_s = {1'b0, rate_r} + {1'b0, step_r};

  // Clip the stepped rate at the stop rate so the stop rate is always measured.
  always_comb begin
    next_rate_s = stop_r;
    if (sum_s >= {1'b0, stop_r}) begin
      next_rate_s = stop_r;
    end else begin
      next_rate_s = sum_s[6:0];
    end
  end

  // Sweep sequencer: one shared counter serves reset hold, settle dwell and ack timeout.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      rate_r        <= 7'd0;
      stop_r        <= 7'd0;
      step_r        <= 7'd0;
      idx_r         <= 7'd0;
      chain_rst_r   <= 1'b1;
      meas_req_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      cfg_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else if (bus.abort && (state_r != S_IDLE)) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      rate_r      <= 7'd0;
      chain_rst_r <= 1'b1;
      meas_req_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.abort) begin
            cfg_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            stop_r        <= bus.cfg_stop_rate;
            step_r        <= bus.cfg_step;
            cnt_r         <= '0;
            if (cfg_valid(bus.cfg_start_rate, bus.cfg_stop_rate, bus.cfg_step)) begin
              state_r <= S_RST_CHAIN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              rate_r  <= bus.cfg_start_rate;
              idx_r   <= 7'd0;
            end else begin
              state_r   <= S_DONE;
              done_r    <= 1'b1;
              cfg_err_r <= 1'b1;
            end
          end
        end
        S_RST_CHAIN: begin
          if (cnt_r == RST_LAST) begin
            state_r     <= S_SETTLE;
            chain_rst_r <= 1'b0;
            cnt_r       <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r    <= S_MEASURE;
            meas_req_r <= 1'b1;
            cnt_r      <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_MEASURE: begin
          if (bus.meas_ack) begin
            state_r    <= S_STEP;
            meas_req_r <= 1'b0;
            cnt_r      <= '0;
          end else if (cnt_r == ACK_LAST) begin
            state_r       <= S_STEP;
            meas_req_r    <= 1'b0;
            timeout_err_r <= 1'b1;
            cnt_r         <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_STEP: begin
          cnt_r <= '0;
          if (rate_r == stop_r) begin
            state_r     <= S_DONE;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            rate_r      <= 7'd0;
            chain_rst_r <= 1'b1;
          end else begin
            state_r <= S_SETTLE;
            rate_r  <= next_rate_s;
            idx_r   <= idx_r + 7'd1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= '0;
          rate_r      <= 7'd0;
          chain_rst_r <= 1'b1;
          meas_req_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.toggle_rate = rate_r;
  assign bus.chain_rst   = chain_rst_r;
  assign bus.meas_req    = meas_req_r;
  assign bus.step_idx    = idx_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.cfg_err     = cfg_err_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_bram_toggle_sweep_ctrl.sv
// Self-checking bench for bram_toggle_sweep_ctrl: directed and randomized sweeps compared
// against a rate-list reference model with cycle-accurate dwell and handshake expectations.
module tb_bram_toggle_sweep_ctrl;
  localparam int RST_C    = 5;
  localparam int SETTLE_C = 12;
  localparam int ACK_C    = 20;
  localparam int BUDGET   = 20000;

  logic clk = 1'b0;
  logic irst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  bram_toggle_sweep_ctrl_if bus();

  bram_toggle_sweep_ctrl #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SETTLE_C), .ACK_TIMEOUT(ACK_C), .CNT_W(20)
  ) dut (
    .clk(clk), .irst_n(irst_n), .bus(bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit cfg_ok(input int s, input int p, input int st);
    return (st >= 1) && (p <= 100) && (s <= p);
  endfunction

  // Reference: list of rates the sweep must measure, in order.
  function automatic void build_rates(input int s, input int p, input int st);
    int r;
    exp_q.delete();
    r = s;
    while (1) begin
      exp_q.push_back(r);
      if (r == p) break;
      r = (r + st > p) ? p : r + st;
    end
  endfunction

  task automatic pulse_start(input int s, input int p, input int st);
    bus.cfg_start_rate = 7'(s);
    bus.cfg_stop_rate  = 7'(p);
    bus.cfg_step       = 7'(st);
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_idle(input string nm, input int exp_done);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, exp_done);
    chk({nm, "_rate"}, bus.toggle_rate, 0);
    chk({nm, "_chain_rst"}, bus.chain_rst, 1);
    chk({nm, "_meas_req"}, bus.meas_req, 0);
  endtask

  // ack_dly < 0 means meas_ack is never given; noise re-pulses start with junk config while busy.
  task automatic run_sweep(input string nm, input int s, input int p, input int st,
                           input int ack_dly, input bit noise);
    int rst_cnt, gap, hi, idx, cyc;
    bit prev_req, seen;
    pulse_start(s, p, st);
    if (!cfg_ok(s, p, st)) begin
      chk({nm, "_cfg_err"}, bus.cfg_err, 1);
      chk({nm, "_timeout_err"}, bus.timeout_err, 0);
      chk_idle(nm, 1);
      seen = 1'b0;
      repeat (RST_C + SETTLE_C + 4) begin
        @(negedge clk);
        if (bus.meas_req || !bus.chain_rst || bus.busy) seen = 1'b1;
      end
      chk({nm, "_no_activity"}, seen, 0);
      return;
    end
    build_rates(s, p, st);
    chk({nm, "_busy0"}, bus.busy, 1);
    chk({nm, "_done0"}, bus.done, 0);
    chk({nm, "_flags0"}, {bus.cfg_err, bus.timeout_err}, 0);
    chk({nm, "_rate0"}, bus.toggle_rate, s);
    chk({nm, "_idx0"}, bus.step_idx, 0);
    rst_cnt = 0; gap = 0; hi = 0; idx = 0; cyc = 0; prev_req = 1'b0;
    while (bus.busy && cyc < BUDGET) begin
      bus.meas_ack = 1'b0;
      bus.start    = 1'b0;
      if (bus.chain_rst) begin
        rst_cnt++;
      end else if (bus.meas_req) begin
        if (!prev_req) begin
          if (idx == 0) chk({nm, "_rst_len"}, rst_cnt, RST_C);
          chk($sformatf("%s_settle%0d", nm, idx), gap, (idx == 0) ? SETTLE_C : SETTLE_C + 1);
          if (idx < exp_q.size()) chk($sformatf("%s_rate%0d", nm, idx), bus.toggle_rate, exp_q[idx]);
          else chk({nm, "_extra_req"}, idx, exp_q.size());
          chk($sformatf("%s_idx%0d", nm, idx), bus.step_idx, idx);
          idx++;
          hi = 0;
          if (noise) begin
            bus.start          = 1'b1;
            bus.cfg_start_rate = 7'($urandom_range(0, 100));
            bus.cfg_stop_rate  = 7'($urandom_range(0, 100));
            bus.cfg_step       = 7'($urandom_range(1, 100));
          end
        end
        hi++;
        if (ack_dly >= 0 && hi == ack_dly + 1) bus.meas_ack = 1'b1;
      end else begin
        if (prev_req) begin
          chk($sformatf("%s_req_len%0d", nm, idx - 1), hi, (ack_dly >= 0) ? ack_dly + 1 : ACK_C);
          gap = 0;
        end
        gap++;
      end
      prev_req = bus.meas_req;
      @(negedge clk);
      cyc++;
    end
    bus.meas_ack = 1'b0;
    bus.start    = 1'b0;
    chk({nm, "_in_budget"}, int'(cyc < BUDGET), 1);
    chk({nm, "_n_req"}, idx, exp_q.size());
    chk({nm, "_timeout_err"}, bus.timeout_err, int'(ack_dly < 0));
    chk({nm, "_cfg_err"}, bus.cfg_err, 0);
    chk_idle(nm, 1);
  endtask

  // Acks every request immediately until the sweep sits at tgt index with meas_req == in_req.
  task automatic advance_to(input string nm, input int tgt, input bit in_req);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < BUDGET && !ok; c++) begin
      bus.meas_ack = 1'b0;
      if (bus.busy && !bus.chain_rst && bus.step_idx == 7'(tgt) && bus.meas_req == in_req) begin
        ok = 1'b1;
      end else begin
        if (bus.meas_req) bus.meas_ack = 1'b1;
        @(negedge clk);
      end
    end
    chk({nm, "_reached"}, ok, 1);
  endtask

  task automatic abort_now(input string nm, input bit with_ack);
    bus.abort    = 1'b1;
    bus.meas_ack = with_ack;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.meas_ack = 1'b0;
    chk_idle(nm, 0);
    chk({nm, "_timeout_err"}, bus.timeout_err, 0);
    repeat (RST_C + SETTLE_C + 4) @(negedge clk);
    chk({nm, "_stays_idle"}, {bus.busy, bus.meas_req, bus.chain_rst}, 1);
  endtask

  initial begin
    int s, p, st, d;
    irst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.meas_ack = 1'b0;
    bus.cfg_start_rate = 7'd0; bus.cfg_stop_rate = 7'd0; bus.cfg_step = 7'd0;
    repeat (3) @(negedge clk);
    chk_idle("rst", 0);
    chk("rst_idx", bus.step_idx, 0);
    chk("rst_flags", {bus.cfg_err, bus.timeout_err}, 0);
    irst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_rst", 0);

    run_sweep("t1", 0, 100, 25, 3, 1'b0);
    run_sweep("t2", 10, 95, 40, 1, 1'b0);
    run_sweep("t3a", 20, 50, 0, 2, 1'b0);
    run_sweep("t3b", 60, 20, 5, 2, 1'b0);
    run_sweep("t3c", 0, 101, 10, 2, 1'b0);
    run_sweep("t4", 0, 0, 1, -1, 1'b0);
    run_sweep("grid", 0, 100, 30, 0, 1'b0);

    pulse_start(0, 100, 25);
    advance_to("t5a", 2, 1'b0);
    abort_now("t5a", 1'b0);
    pulse_start(0, 100, 25);
    advance_to("t5b", 0, 1'b1);
    abort_now("t5b", 1'b1);

    bus.cfg_start_rate = 7'd0; bus.cfg_stop_rate = 7'd50; bus.cfg_step = 7'd10;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk_idle("start_abort", 0);

    pulse_start(20, 80, 20);
    advance_to("t6", 1, 1'b1);
    #2 irst_n = 1'b0;
    #1;
    chk_idle("t6_async", 0);
    chk("t6_async_idx", bus.step_idx, 0);
    chk("t6_async_flags", {bus.cfg_err, bus.timeout_err}, 0);
    @(negedge clk);
    irst_n = 1'b1;
    @(negedge clk);
    run_sweep("t6_noise", 5, 77, 9, 2, 1'b1);

    for (int i = 0; i < 10; i++) begin
      s  = $urandom_range(0, 100);
      p  = $urandom_range(s, 100);
      st = $urandom_range(3, 60);
      if ($urandom_range(0, 4) == 0) p = $urandom_range(101, 127);
      if ($urandom_range(0, 6) == 0) st = 0;
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
      run_sweep($sformatf("rnd%0d", i), s, p, st, d, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
